// File: rtl/regfile_write_queue_pkg.sv
// regfile_pkg: definitions shared by the register file, its writer-side
// queue (regfile_write_queue) and their testbenches.
//   DATA_W   - writeback data width
//   IDX_W    - register index width
//   ZERO_REG - hard-wired zero register (XZR); writes to it are discarded
//   wb_entry_t - one queued writeback {rd, data}
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int IDX_W    = 5;
  localparam int ZERO_REG = 31;

  typedef struct packed {
    logic [IDX_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_write_queue_if.sv
// regfile_write_queue_if: bundles the two producer handshakes, the register
// file write port, the occupancy output and (with REGFILE_WQ_FORWARD_EN
// defined) the decode-stage forwarding lookup.
//   slave  modport - used by regfile_write_queue
//   master modport - used by whatever drives the producers / watches the port
interface regfile_write_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int IDX_W  = regfile_pkg::IDX_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic              alu_ready;
  logic [IDX_W-1:0]  alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [IDX_W-1:0]  mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              reg_write;
  logic [IDX_W-1:0]  write_register;
  logic [DATA_W-1:0] write_data;
  logic [CNT_W-1:0]  pending;
`ifdef REGFILE_WQ_FORWARD_EN
  logic [IDX_W-1:0]  fwd_reg;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, fwd_reg,
    output alu_ready, mem_ready, reg_write, write_register, write_data,
           pending, fwd_hit, fwd_data
  );
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, fwd_reg,
    input  alu_ready, mem_ready, reg_write, write_register, write_data,
           pending, fwd_hit, fwd_data
  );
`else
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, reg_write, write_register, write_data, pending
  );
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, reg_write, write_register, write_data, pending
  );
`endif
endinterface

// File: rtl/regfile_write_queue_wb_fifo.sv
// wb_fifo: in-order FIFO of wb_entry_t with two push lanes and one pop lane.
// Lane 0 is older than lane 1; when both push, lane 0 lands first.
//   clk, rst       - clock, asynchronous active-high reset (control only)
//   push0/entry    - older push lane
//   push1/entry    - younger push lane
//   pop            - retire head (caller only pops when count != 0)
//   head           - entry at read pointer
//   count          - occupancy
//   entries, rd_ptr_o - raw storage view (REGFILE_WQ_FORWARD_EN only)
// The caller guarantees pushes never exceed free space.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push0,
  input  wb_entry_t        push0_entry,
  input  logic             push1,
  input  wb_entry_t        push1_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count
`ifdef REGFILE_WQ_FORWARD_EN
  ,
  output wb_entry_t        entries [DEPTH],
  output logic [PTR_W-1:0] rd_ptr_o
`endif
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] push1_idx;
  logic [1:0]       n_push;
  wb_entry_t        mem_q [DEPTH];

  assign n_push    = {1'b0, push0} + {1'b0, push1};
  // Lane 1 goes one slot past lane 0 only if lane 0 actually pushed.
  assign push1_idx = push0 ? wr_ptr + PTR_W'(1) : wr_ptr;

  // Pointers are PTR_W wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(n_push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push0) mem_q[wr_ptr]    <= push0_entry;
    if (push1) mem_q[push1_idx] <= push1_entry;
  end

  assign head = mem_q[rd_ptr];

`ifdef REGFILE_WQ_FORWARD_EN
  assign entries  = mem_q;
  assign rd_ptr_o = rd_ptr;
`endif

endmodule

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: writer-side front end for the 32 x 64-bit register
// file. Accepts results from the ALU and the load unit over valid/ready,
// queues them in order (load before ALU on the same edge) and retires one
// write per cycle through the register file's single write port.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; flushes the queue
//   bus  - regfile_write_queue_if.slave: producer handshakes, write port
//          (reg_write/write_register/write_data), pending occupancy and,
//          with REGFILE_WQ_FORWARD_EN defined, fwd_reg/fwd_hit/fwd_data.
// Optional feature macro: REGFILE_WQ_FORWARD_EN (newest-match lookup of
// queued results for the decode stage).
module regfile_write_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int IDX_W    = regfile_pkg::IDX_W,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input logic                  clk,
  input logic                  rst,
  regfile_write_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] count;
  wb_entry_t        head;
  logic             room1;
  logic             room2;
  logic             mem_fire;
  logic             alu_fire;
  logic             push_mem;
  logic             push_alu;
  logic             draining;
  wb_entry_t        mem_entry;
  wb_entry_t        alu_entry;

`ifdef REGFILE_WQ_FORWARD_EN
  wb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] fwd_idx;
`endif

  // Ready looks only at the registered count: no credit for this cycle's pop.
  // The ALU needs two free slots when the load unit may take one alongside it.
  assign room1         = (count <= CNT_W'(DEPTH - 1));
  assign room2         = (count <= CNT_W'(DEPTH - 2));
  assign bus.mem_ready = !rst && room1;
  assign bus.alu_ready = !rst && (room2 || (!bus.mem_valid && room1));

  assign mem_fire = bus.mem_valid && bus.mem_ready;
  assign alu_fire = bus.alu_valid && bus.alu_ready;

  // XZR results complete the handshake but never occupy a slot.
  assign push_mem = mem_fire && (bus.mem_rd != IDX_W'(ZERO_REG));
  assign push_alu = alu_fire && (bus.alu_rd != IDX_W'(ZERO_REG));

  assign mem_entry = '{rd: bus.mem_rd, data: bus.mem_data};
  assign alu_entry = '{rd: bus.alu_rd, data: bus.alu_data};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push0       (push_mem),
    .push0_entry (mem_entry),
    .push1       (push_alu),
    .push1_entry (alu_entry),
    .pop         (draining),
    .head        (head),
    .count       (count)
`ifdef REGFILE_WQ_FORWARD_EN
    ,
    .entries     (entries),
    .rd_ptr_o    (rd_ptr)
`endif
  );

  // Head drives the write port combinationally and pops on the same edge
  // the register file captures it.
  assign draining           = (count != '0);
  assign bus.reg_write      = draining;
  assign bus.write_register = draining ? head.rd : '0;
  assign bus.write_data     = draining ? head.data : DATA_W'(0);
  assign bus.pending        = count;

`ifdef REGFILE_WQ_FORWARD_EN
  // Walk oldest to newest over the live entries; the last match wins.
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    fwd_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entries[fwd_idx].rd == bus.fwd_reg) &&
          (bus.fwd_reg != IDX_W'(ZERO_REG))) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = entries[fwd_idx].data;
      end
    end
  end
`endif

endmodule
